// File: rtl/mem_access_stage_pkg.sv
// Shared core types for the memory stage: op/writeback structs, FSM and LSU funct3 enums,
// plus byte-enable, store-lane and legality helpers used by mem_access_stage.
package corePckg;

  localparam int cXLEN     = 32;
  localparam int cBeBitW   = cXLEN / 8;
  localparam int cRegAddrW = 5;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eReq  = 1'b1
  } tMemFsmEnum;

  typedef enum logic [2:0] {
    eLb  = 3'b000,
    eLh  = 3'b001,
    eLw  = 3'b010,
    eLbu = 3'b100,
    eLhu = 3'b101
  } tLsuFunct3Enum;

  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [cXLEN-1:0]     addr;
    logic [cXLEN-1:0]     data;
    logic [2:0]           opType;
    logic [cRegAddrW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                 dv;
    logic [cRegAddrW-1:0] addr;
    logic [cXLEN-1:0]     data;
  } tRegOp;

  // size: funct3[1:0] (00 byte, 01 half, 10 word); lane: addr[1:0]
  function automatic logic [cBeBitW-1:0] lsuByteEn(input logic [1:0] size,
                                                   input logic [1:0] lane);
    logic [cBeBitW-1:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [cXLEN-1:0] lsuStoreData(input logic [1:0]       size,
                                                    input logic [cXLEN-1:0] data);
    logic [cXLEN-1:0] wd;
    case (size)
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  function automatic logic lsuMisaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic lsuLegal(input logic isStore, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      eLb, eLh, eLw: ok = 1'b1;
      eLbu, eLhu:    ok = !isStore;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Combinational load lane select and sign/zero extension; shared with forwarding logic.
module load_extend
  import corePckg::*;
(
  input  logic [cXLEN-1:0] iRdata,
  input  logic [1:0]       iAddrLo,
  input  logic [2:0]       iFunct3,
  output logic [cXLEN-1:0] oResult
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = iRdata[8*iAddrLo +: 8];
    w_half  = iAddrLo[1] ? iRdata[31:16] : iRdata[15:0];
    oResult = iRdata;
    case (iFunct3)
      eLb:     oResult = {{24{w_byte[7]}}, w_byte};
      eLh:     oResult = {{16{w_half[15]}}, w_half};
      eLbu:    oResult = {24'h0, w_byte};
      eLhu:    oResult = {16'h0, w_half};
      default: oResult = iRdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: one load/store at a time over a req/ack data-memory port.
// Optional ack watchdog (oExcBusTimeout) is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage
  import corePckg::*;
#(
  parameter int pTimeoutCycles = 255,
  parameter int pCntBitW       = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  tMemOp              iMemOp,
  input  logic               iMemOpDv,
  output logic               oBusy,
  output logic               oDmemReq,
  output logic               oDmemWe,
  output logic [cXLEN-1:0]   oDmemAddr,
  output logic [cBeBitW-1:0] oDmemBe,
  output logic [cXLEN-1:0]   oDmemWdata,
  input  logic               iDmemAck,
  input  logic [cXLEN-1:0]   iDmemRdata,
  output tRegOp              oRegOp,
  output logic               oExcMisalign,
  output logic               oExcIllegal
`ifdef MEM_TIMEOUT_EN
  ,
  output logic               oExcBusTimeout
`endif
);

  if ((2 ** pCntBitW) <= pTimeoutCycles) begin : g_badCntWidth
    $error("pCntBitW too narrow for pTimeoutCycles");
  end

  tMemFsmEnum           r_state;
  tMemFsmEnum           w_stateNxt;
  logic                 w_accept;
  logic                 w_misalign;
  logic                 w_illegal;
  logic                 w_done;
  logic                 r_we;
  logic [cXLEN-1:0]     r_dmemAddr;
  logic [1:0]           r_addrLo;
  logic [cBeBitW-1:0]   r_be;
  logic [cXLEN-1:0]     r_wdata;
  logic [2:0]           r_funct3;
  logic [cRegAddrW-1:0] r_rd;
  tRegOp                r_regOp;
  logic                 r_excMis;
  logic                 r_excIll;
  logic [cXLEN-1:0]     w_ldResult;

`ifdef MEM_TIMEOUT_EN
  localparam logic [pCntBitW-1:0] cTimeoutLast = pCntBitW'(pTimeoutCycles - 1);
  logic [pCntBitW-1:0] r_cnt;
  logic                r_excTimeout;
  logic                w_timeout;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n) r_state <= eIdle;
    else         r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt = r_state;
    w_accept   = 1'b0;
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    case (r_state)
      eIdle: begin
        if (iMemOpDv) begin
          if (iMemOp.read && iMemOp.write) begin
            w_illegal = 1'b1;
          end else if (iMemOp.read || iMemOp.write) begin
            if (!lsuLegal(iMemOp.write, iMemOp.opType)) begin
              w_illegal = 1'b1;
            end else if (lsuMisaligned(iMemOp.opType[1:0], iMemOp.addr[1:0])) begin
              w_misalign = 1'b1;
            end else begin
              w_accept   = 1'b1;
              w_stateNxt = eReq;
            end
          end
        end
      end
      eReq: begin
        // Ack wins over a watchdog expiry landing on the same cycle
        if (iDmemAck) begin
          w_done     = 1'b1;
          w_stateNxt = eIdle;
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_cnt == cTimeoutLast) begin
          w_timeout  = 1'b1;
          w_stateNxt = eIdle;
        end
`endif
      end
      default: w_stateNxt = eIdle;
    endcase
  end

  load_extend u_loadExtend (
    .iRdata  (iDmemRdata),
    .iAddrLo (r_addrLo),
    .iFunct3 (r_funct3),
    .oResult (w_ldResult)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_we       <= 1'b0;
      r_dmemAddr <= '0;
      r_addrLo   <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_regOp    <= '0;
      r_excMis   <= 1'b0;
      r_excIll   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= iMemOp.write;
        r_dmemAddr <= {iMemOp.addr[cXLEN-1:2], 2'b00};
        r_addrLo   <= iMemOp.addr[1:0];
        r_be       <= lsuByteEn(iMemOp.opType[1:0], iMemOp.addr[1:0]);
        r_wdata    <= lsuStoreData(iMemOp.opType[1:0], iMemOp.data);
        r_funct3   <= iMemOp.opType;
        r_rd       <= iMemOp.rdAddr;
      end
      r_excMis   <= w_misalign;
      r_excIll   <= w_illegal;
      r_regOp.dv <= 1'b0;
      // x0 loads still complete on the bus but never write back
      if (w_done && !r_we && (r_rd != '0)) begin
        r_regOp.dv   <= 1'b1;
        r_regOp.addr <= r_rd;
        r_regOp.data <= w_ldResult;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_cnt        <= '0;
      r_excTimeout <= 1'b0;
    end else begin
      r_excTimeout <= w_timeout;
      if (w_accept)                             r_cnt <= '0;
      else if ((r_state == eReq) && !iDmemAck) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign oExcBusTimeout = r_excTimeout;
`endif

  assign oBusy        = (r_state == eReq);
  assign oDmemReq     = (r_state == eReq);
  assign oDmemWe      = r_we;
  assign oDmemAddr    = r_dmemAddr;
  assign oDmemBe      = r_be;
  assign oDmemWdata   = r_wdata;
  assign oRegOp       = r_regOp;
  assign oExcMisalign = r_excMis;
  assign oExcIllegal  = r_excIll;

endmodule
